// File: rtl/seq_path_checker.sv
// Receive-side checker for the 4-bit sequencer state-code stream.
// Validates each beat against the legal transition graph, latches the first
// violation (pair and cause), counts completed 5->1 loops and flags stalls.
module seq_path_checker #(
   parameter int unsigned CNT_W     = 8,
   parameter int unsigned GAP_LIMIT = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [3:0]       in_code,
   input  logic             in_sel,
   output logic             tracking,
   output logic             err,
   output logic [1:0]       err_cause,
   output logic [3:0]       err_prev,
   output logic [3:0]       err_code,
   output logic [CNT_W-1:0] loop_cnt
);

   localparam int unsigned CODE_W  = 4;
   localparam int unsigned CAUSE_W = 2;
   // Counter only needs to hold 0..GAP_LIMIT-1; the hit is detected one early.
   localparam int unsigned GAP_W   = (GAP_LIMIT < 2) ? 1 : $clog2(GAP_LIMIT);
   localparam bit          GAP_EN  = (GAP_LIMIT != 0);

   localparam logic [CAUSE_W-1:0] CAUSE_NONE  = CAUSE_W'(0);
   localparam logic [CAUSE_W-1:0] CAUSE_SUCC  = CAUSE_W'(1);
   localparam logic [CAUSE_W-1:0] CAUSE_START = CAUSE_W'(2);
   localparam logic [CAUSE_W-1:0] CAUSE_GAP   = CAUSE_W'(3);

   localparam logic [CODE_W-1:0] C_START = CODE_W'(0);
   localparam logic [CODE_W-1:0] C_LOOP  = CODE_W'(5);
   localparam logic [CODE_W-1:0] C_WRAP  = CODE_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRACK = 2'd1,
      ST_ERROR = 2'd2
   } state_t;

   state_t              state, state_nxt;

   logic [CODE_W-1:0]   prev_code, prev_code_nxt;
   logic                prev_sel, prev_sel_nxt;
   logic [GAP_W-1:0]    gap_cnt, gap_cnt_nxt;

   logic                tracking_nxt;
   logic                err_nxt;
   logic [CAUSE_W-1:0]  err_cause_nxt;
   logic [CODE_W-1:0]   err_prev_nxt;
   logic [CODE_W-1:0]   err_code_nxt;
   logic [CNT_W-1:0]    loop_cnt_nxt;

   logic [CODE_W-1:0]   exp_code;
   logic                exp_ok;
   logic                beat_ok;
   logic                gap_hit;
   logic                loop_done;
   logic                loop_sat;

   // Expected successor of the last accepted code; exp_ok=0 means no legal successor.
   always_comb begin
      exp_code = '0;
      exp_ok   = 1'b0;
      case (prev_code)
         CODE_W'(0):  begin exp_code = CODE_W'(8);  exp_ok = 1'b1; end
         CODE_W'(8):  begin exp_code = CODE_W'(10); exp_ok = 1'b1; end
         CODE_W'(10): begin exp_code = CODE_W'(1);  exp_ok = 1'b1; end
         CODE_W'(1):  begin exp_code = CODE_W'(2);  exp_ok = 1'b1; end
         CODE_W'(2):  begin
            exp_code = prev_sel ? CODE_W'(5) : CODE_W'(6);
            exp_ok   = 1'b1;
         end
         CODE_W'(6):  begin exp_code = CODE_W'(7);  exp_ok = 1'b1; end
         CODE_W'(7):  begin exp_code = CODE_W'(5);  exp_ok = 1'b1; end
         CODE_W'(5):  begin exp_code = CODE_W'(1);  exp_ok = 1'b1; end
         default:     begin exp_code = '0;          exp_ok = 1'b0; end
      endcase
   end

   // Beat qualification, loop detection and stall detection.
   always_comb begin
      beat_ok   = in_valid && exp_ok && (in_code == exp_code);
      loop_done = (prev_code == C_LOOP) && (in_code == C_WRAP);
      loop_sat  = &loop_cnt;
      gap_hit   = GAP_EN && (gap_cnt == GAP_W'(GAP_LIMIT - 1));
   end

   // Next-state and next-output logic; ERROR holds everything until reset.
   always_comb begin
      state_nxt     = state;
      prev_code_nxt = prev_code;
      prev_sel_nxt  = prev_sel;
      gap_cnt_nxt   = gap_cnt;
      err_cause_nxt = err_cause;
      err_prev_nxt  = err_prev;
      err_code_nxt  = err_code;
      loop_cnt_nxt  = loop_cnt;

      case (state)
         ST_IDLE: begin
            if (in_valid) begin
               if (in_code == C_START) begin
                  state_nxt     = ST_TRACK;
                  prev_code_nxt = C_START;
                  prev_sel_nxt  = in_sel;
                  gap_cnt_nxt   = '0;
               end else begin
                  state_nxt     = ST_ERROR;
                  err_cause_nxt = CAUSE_START;
                  err_prev_nxt  = '0;
                  err_code_nxt  = in_code;
               end
            end
         end

         ST_TRACK: begin
            if (in_valid) begin
               if (beat_ok) begin
                  prev_code_nxt = in_code;
                  prev_sel_nxt  = in_sel;
                  gap_cnt_nxt   = '0;
                  if (loop_done && !loop_sat) begin
                     loop_cnt_nxt = loop_cnt + CNT_W'(1);
                  end
               end else begin
                  state_nxt     = ST_ERROR;
                  err_cause_nxt = CAUSE_SUCC;
                  err_prev_nxt  = prev_code;
                  err_code_nxt  = in_code;
               end
            end else if (GAP_EN) begin
               if (gap_hit) begin
                  state_nxt     = ST_ERROR;
                  err_cause_nxt = CAUSE_GAP;
                  err_prev_nxt  = prev_code;
                  err_code_nxt  = '0;
               end else begin
                  gap_cnt_nxt = gap_cnt + GAP_W'(1);
               end
            end
         end

         ST_ERROR: begin
            state_nxt = ST_ERROR;
         end

         default: begin
            state_nxt     = ST_ERROR;
            err_cause_nxt = CAUSE_NONE;
         end
      endcase

      tracking_nxt = (state_nxt == ST_TRACK);
      err_nxt      = (state_nxt == ST_ERROR);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Registered outputs and tracking context.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_code <= '0;
         prev_sel  <= 1'b0;
         gap_cnt   <= '0;
         tracking  <= 1'b0;
         err       <= 1'b0;
         err_cause <= CAUSE_NONE;
         err_prev  <= '0;
         err_code  <= '0;
         loop_cnt  <= '0;
      end else begin
         prev_code <= prev_code_nxt;
         prev_sel  <= prev_sel_nxt;
         gap_cnt   <= gap_cnt_nxt;
         tracking  <= tracking_nxt;
         err       <= err_nxt;
         err_cause <= err_cause_nxt;
         err_prev  <= err_prev_nxt;
         err_code  <= err_code_nxt;
         loop_cnt  <= loop_cnt_nxt;
      end
   end

endmodule
